// File: rtl/sbox_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sbox_sched_pkg
// Description : Shared types and constants for the masked S-box layer
//               scheduler: FSM state encoding, nibble width and the
//               {valid, idx} tag carried alongside the S-box pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package sbox_sched_pkg;

    localparam int NIBBLE_W = 4;
    localparam int c_IDX_W  = 4;

    // Scheduler FSM states
    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE  = 2'd0;
    localparam state_t c_ST_ISSUE = 2'd1;
    localparam state_t c_ST_DRAIN = 2'd2;
    localparam state_t c_ST_DONE  = 2'd3;

    // Tag travelling in lock-step with one S-box lookup
    typedef struct packed {
        logic               valid;
        logic [c_IDX_W-1:0] idx;
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/sbox_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sbox_tag_pipe
// Description : LATENCY-deep shift register of {valid, idx} tags that mirrors
//               the register stages of the external masked S-box, so the
//               tag at the output belongs to the S-box output shares.
// Revision    : 1.0 - initial release
// ============================================================================
module sbox_tag_pipe
    import sbox_sched_pkg::*;
#(
    parameter int LATENCY = 9
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out,
    output logic any_valid
);

    tag_t [LATENCY-1:0] r_stage;

    // Shift one tag per cycle; stage 0 takes the tag of this cycle's issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage <= '0;
        end else begin
            r_stage[0] <= tag_in;
            for (int i = 1; i < LATENCY; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    // Flag any lookup still in flight in the S-box
    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            any_valid = any_valid | r_stage[i].valid;
        end
    end

    assign tag_out = r_stage[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/sbox_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sbox_layer_scheduler
// Description : Feeds the nibbles of a two-share state through an external
//               pipelined masked S-box one per cycle (only when fresh
//               randomness is available), collects the output shares by tag
//               and pulses done when the whole layer is substituted.
//               Optional macro SBOX_SCHED_ZEROIZE_EN: clear the result and
//               the latched input once the done cycle has passed.
// Revision    : 1.0 - initial release
// ============================================================================
module sbox_layer_scheduler
    import sbox_sched_pkg::*;
#(
    parameter int LATENCY = 9,
    parameter int NIBBLES = 16,
    parameter int FRESH_W = 17
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] state_s0,
    input  logic [NIBBLE_W*NIBBLES-1:0] state_s1,
    input  logic [FRESH_W-1:0]          rnd_in,
    input  logic                        rnd_valid,
    output logic [NIBBLE_W-1:0]         SI_s0,
    output logic [NIBBLE_W-1:0]         SI_s1,
    output logic [FRESH_W-1:0]          Fresh,
    input  logic [NIBBLE_W-1:0]         SO_s0,
    input  logic [NIBBLE_W-1:0]         SO_s1,
    output logic [NIBBLE_W*NIBBLES-1:0] result_s0,
    output logic [NIBBLE_W*NIBBLES-1:0] result_s1,
    output logic                        done,
    output logic                        rnd_starve
);

    localparam int                 c_STATE_W  = NIBBLE_W * NIBBLES;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NIBBLES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_IDX_W-1:0] r_idx;
    logic [c_STATE_W-1:0] r_in_s0;
    logic [c_STATE_W-1:0] r_in_s1;
    logic [c_STATE_W-1:0] r_res_s0;
    logic [c_STATE_W-1:0] r_res_s1;
    logic               r_starve;
    logic               w_accept;
    logic               w_issue;
    logic               w_last_issue;
    logic               w_drain_done;
    logic               w_any_valid;
    logic               w_zeroize;
    tag_t               w_tag_in;
    tag_t               w_tag_out;

    assign w_accept     = (r_state == c_ST_IDLE) && start;
    assign w_issue      = (r_state == c_ST_ISSUE) && rnd_valid;
    assign w_last_issue = w_issue && (r_idx == c_LAST_IDX);
    // Tags leave in issue order, so the last nibble's tag ends the layer
    assign w_drain_done = (r_state == c_ST_DRAIN) && w_tag_out.valid &&
                          (w_tag_out.idx == c_LAST_IDX);
    assign w_tag_in     = '{valid: w_issue, idx: r_idx};

`ifdef SBOX_SCHED_ZEROIZE_EN
    assign w_zeroize = (r_state == c_ST_DONE);
`else
    assign w_zeroize = 1'b0;
`endif

    sbox_tag_pipe #(
        .LATENCY (LATENCY)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .tag_in    (w_tag_in),
        .tag_out   (w_tag_out),
        .any_valid (w_any_valid)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (start)        w_state_nxt = c_ST_ISSUE;
            c_ST_ISSUE: if (w_last_issue) w_state_nxt = c_ST_DRAIN;
            c_ST_DRAIN: if (w_drain_done) w_state_nxt = c_ST_DONE;
            c_ST_DONE:                    w_state_nxt = c_ST_IDLE;
            default:                      w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Latch the input shares on acceptance and step the issue index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_s0 <= '0;
            r_in_s1 <= '0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_in_s0 <= state_s0;
            r_in_s1 <= state_s1;
            r_idx   <= '0;
        end else if (w_zeroize) begin
            r_in_s0 <= '0;
            r_in_s1 <= '0;
        end else if (w_issue) begin
            r_idx   <= r_idx + 1'b1;
        end
    end

    // Write each returning S-box output into the nibble named by its tag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_s0 <= '0;
            r_res_s1 <= '0;
        end else if (w_zeroize) begin
            r_res_s0 <= '0;
            r_res_s1 <= '0;
        end else if (w_tag_out.valid) begin
            r_res_s0[NIBBLE_W*int'(w_tag_out.idx) +: NIBBLE_W] <= SO_s0;
            r_res_s1[NIBBLE_W*int'(w_tag_out.idx) +: NIBBLE_W] <= SO_s1;
        end
    end

    // Sticky starvation flag, re-armed by each accepted layer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= 1'b0;
        end else if (w_accept) begin
            r_starve <= 1'b0;
        end else if (!rnd_valid && (w_any_valid || (r_state == c_ST_ISSUE))) begin
            r_starve <= 1'b1;
        end
    end

    // Drive the current nibble shares only on real issue cycles
    always_comb begin
        SI_s0 = '0;
        SI_s1 = '0;
        if (w_issue) begin
            SI_s0 = r_in_s0[NIBBLE_W*int'(r_idx) +: NIBBLE_W];
            SI_s1 = r_in_s1[NIBBLE_W*int'(r_idx) +: NIBBLE_W];
        end
    end

    assign Fresh      = ((r_state == c_ST_ISSUE) || (r_state == c_ST_DRAIN)) ? rnd_in : '0;
    assign ready      = (r_state == c_ST_IDLE);
    assign done       = (r_state == c_ST_DONE);
    assign result_s0  = r_res_s0;
    assign result_s1  = r_res_s1;
    assign rnd_starve = r_starve;

endmodule
`default_nettype wire

// File: tb/tb_sbox_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_sbox_layer_scheduler
// Description : Self-checking bench for sbox_layer_scheduler with a
//               behavioural masked SKINNY-style S-box of LATENCY stages and
//               a layer-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sbox_layer_scheduler;

    localparam int LAT = 9;
    localparam int NIB = 16;
    localparam int FW  = 17;
    localparam int SW  = 4 * NIB;

    localparam int P_IDLE  = 0;
    localparam int P_ISSUE = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;

    logic          clk;
    logic          rst;
    logic          start;
    logic          ready;
    logic [SW-1:0] state_s0;
    logic [SW-1:0] state_s1;
    logic [FW-1:0] rnd_in;
    logic          rnd_valid;
    logic [3:0]    SI_s0;
    logic [3:0]    SI_s1;
    logic [FW-1:0] Fresh;
    logic [3:0]    SO_s0;
    logic [3:0]    SO_s1;
    logic [SW-1:0] result_s0;
    logic [SW-1:0] result_s1;
    logic          done;
    logic          rnd_starve;

    int n_tests = 0;
    int n_fail  = 0;

    sbox_layer_scheduler #(
        .LATENCY (LAT),
        .NIBBLES (NIB),
        .FRESH_W (FW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ready      (ready),
        .state_s0   (state_s0),
        .state_s1   (state_s1),
        .rnd_in     (rnd_in),
        .rnd_valid  (rnd_valid),
        .SI_s0      (SI_s0),
        .SI_s1      (SI_s1),
        .Fresh      (Fresh),
        .SO_s0      (SO_s0),
        .SO_s1      (SO_s1),
        .result_s0  (result_s0),
        .result_s1  (result_s1),
        .done       (done),
        .rnd_starve (rnd_starve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] sk4(input logic [3:0] x);
        logic [63:0] t;
        t = 64'hC6901A2B385D4E7F;
        return t[4*(15-int'(x)) +: 4];
    endfunction

    function automatic logic [SW-1:0] layer(input logic [SW-1:0] x);
        logic [SW-1:0] r;
        r = '0;
        for (int i = 0; i < NIB; i++) r[4*i +: 4] = sk4(x[4*i +: 4]);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // External masked S-box: unmask, substitute, remask with Fresh, delay LAT stages
    logic [7:0] sb_q [LAT];
    always @(posedge clk) begin
        logic [3:0] y;
        y = sk4(SI_s0 ^ SI_s1);
        sb_q[0] <= {y ^ Fresh[3:0], Fresh[3:0]};
        for (int i = 1; i < LAT; i++) sb_q[i] <= sb_q[i-1];
    end
    assign SO_s0 = sb_q[LAT-1][7:4];
    assign SO_s1 = sb_q[LAT-1][3:0];

    // Layer-level reference model
    int            ph         = P_IDLE;
    int            nxt        = 0;
    int            cnt        = 0;
    logic          m_starve   = 1'b0;
    int            m_res_kind = 2;     // 0 unknown, 1 xor known, 2 both zero
    logic [SW-1:0] m_res      = '0;
    logic [SW-1:0] m_s0       = '0;
    logic [SW-1:0] m_s1       = '0;

    always @(posedge clk) begin
        if (rst) begin
            ph = P_IDLE; m_starve = 1'b0; m_res_kind = 2; m_res = '0;
        end else begin
            case (ph)
                P_IDLE: if (start) begin
                    ph = P_ISSUE; nxt = 0; m_s0 = state_s0; m_s1 = state_s1;
                    m_starve = 1'b0; m_res_kind = 0;
                end
                P_ISSUE: begin
                    if (!rnd_valid) m_starve = 1'b1;
                    else begin
                        nxt++;
                        if (nxt == NIB) begin ph = P_DRAIN; cnt = LAT; end
                    end
                end
                P_DRAIN: begin
                    if (!rnd_valid) m_starve = 1'b1;
                    cnt--;
                    if (cnt == 0) begin
                        ph = P_DONE; m_res_kind = 1; m_res = layer(m_s0 ^ m_s1);
                    end
                end
                default: begin
                    ph = P_IDLE;
`ifdef SBOX_SCHED_ZEROIZE_EN
                    m_res_kind = 2;
`endif
                end
            endcase
        end
    end

    // Compare DUT against the model on every falling edge
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ready", 64'(ready), 64'd1);
            chk("rst_done", 64'(done), 64'd0);
            chk("rst_si", 64'({SI_s0, SI_s1}), 64'd0);
            chk("rst_fresh", 64'(Fresh), 64'd0);
            chk("rst_starve", 64'(rnd_starve), 64'd0);
            chk("rst_res", result_s0 | result_s1, 64'd0);
        end else begin
            logic iss;
            iss = (ph == P_ISSUE) && rnd_valid;
            chk("ready", 64'(ready), 64'(ph == P_IDLE));
            chk("done", 64'(done), 64'(ph == P_DONE));
            chk("starve", 64'(rnd_starve), 64'(m_starve));
            chk("fresh", 64'(Fresh), (ph == P_ISSUE || ph == P_DRAIN) ? 64'(rnd_in) : 64'd0);
            chk("si_s0", 64'(SI_s0), iss ? 64'(m_s0[4*nxt +: 4]) : 64'd0);
            chk("si_s1", 64'(SI_s1), iss ? 64'(m_s1[4*nxt +: 4]) : 64'd0);
            if (m_res_kind == 1) chk("result", result_s0 ^ result_s1, m_res);
            else if (m_res_kind == 2) begin
                chk("res_s0_zero", result_s0, 64'd0);
                chk("res_s1_zero", result_s1, 64'd0);
            end
        end
    end

    // One layer: bubbles on edges b_lo..b_hi, optional start pulse and reset
    task automatic run_layer(input logic [SW-1:0] x, input logic [SW-1:0] m,
                             input int b_lo, input int b_hi, input int pulse_k,
                             input int rst_k, input int max_k, input bit stop,
                             output int done_k, output int n_done);
        @(posedge clk); #1;
        start = 1'b1; state_s0 = x ^ m; state_s1 = m;
        rnd_valid = 1'b1; rnd_in = FW'($urandom);
        @(negedge clk);
        chk("accept_ready", 64'(ready), 64'd1);
        @(posedge clk);
        done_k = -1; n_done = 0;
        for (int k = 0; k < max_k; k++) begin
            #1;
            start = (k == pulse_k);
            if (k == pulse_k) state_s0 = ~state_s0;
            rnd_valid = !(k >= b_lo && k <= b_hi);
            rnd_in = FW'($urandom);
            if (k == rst_k) rst = 1'b1;
            if (k == rst_k + 1) rst = 1'b0;
            @(negedge clk);
            if (done) begin
                n_done++;
                if (done_k < 0) done_k = k + 1;
                if (stop) break;
            end
            @(posedge clk);
        end
        start = 1'b0;
    endtask

    localparam logic [SW-1:0] X1 = 64'h0123456789ABCDEF;
    localparam logic [SW-1:0] M1 = 64'hA5A5A5A5A5A5A5A5;
    localparam logic [SW-1:0] X2 = 64'hFEDCBA9876543210;
    localparam logic [SW-1:0] M2 = 64'h3C3C0F0F96695AA5;
    localparam logic [SW-1:0] R1 = 64'hC6901A2B385D4E7F;
    localparam logic [SW-1:0] R2 = 64'hF7E4D583B2A1096C;

    initial begin
        int dk;
        int nd;
        rst = 1'b1; start = 1'b0; rnd_valid = 1'b1; rnd_in = '0;
        state_s0 = '0; state_s1 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", 64'(ready), 64'd1);
        chk("reset_result", result_s0 | result_s1, 64'd0);

        // Basic layer
        run_layer(X1, M1, -1, -2, -1, -1, 60, 1'b1, dk, nd);
        chk("t1_done_cycle", 64'(dk), 64'd26);
        chk("t1_result", result_s0 ^ result_s1, R1);
        chk("t1_starve", 64'(rnd_starve), 64'd0);

        // Three bubbles during issue
        run_layer(X1, M1, 2, 4, -1, -1, 60, 1'b1, dk, nd);
        chk("t2_done_cycle", 64'(dk), 64'd29);
        chk("t2_result", result_s0 ^ result_s1, R1);
        chk("t2_starve", 64'(rnd_starve), 64'd1);

        // Back-to-back second layer clears starvation
        run_layer(X2, M2, -1, -2, -1, -1, 60, 1'b1, dk, nd);
        chk("t3_done_cycle", 64'(dk), 64'd26);
        chk("t3_result", result_s0 ^ result_s1, R2);
        chk("t3_starve", 64'(rnd_starve), 64'd0);

        // Start pulse (with altered input) during issue is ignored
        run_layer(X1, M2, -1, -2, 5, -1, 45, 1'b0, dk, nd);
        chk("t4_done_count", 64'(nd), 64'd1);
        chk("t4_done_cycle", 64'(dk), 64'd26);
        @(negedge clk);
`ifdef SBOX_SCHED_ZEROIZE_EN
        chk("t4_result_zeroized", result_s0 | result_s1, 64'd0);
`else
        chk("t4_result_held", result_s0 ^ result_s1, R1);
`endif

        // Reset while draining aborts the layer
        run_layer(X2, M1, -1, -2, -1, 20, 45, 1'b0, dk, nd);
        chk("t5_done_count", 64'(nd), 64'd0);
        @(negedge clk);
        chk("t5_ready", 64'(ready), 64'd1);
        chk("t5_result", result_s0 | result_s1, 64'd0);

        // Recovery after abort
        run_layer(X2, M1, -1, -2, -1, -1, 60, 1'b1, dk, nd);
        chk("t6_done_cycle", 64'(dk), 64'd26);
        chk("t6_result", result_s0 ^ result_s1, R2);
        repeat (3) @(posedge clk);
        @(negedge clk);
`ifdef SBOX_SCHED_ZEROIZE_EN
        chk("t6_result_zeroized", result_s0 | result_s1, 64'd0);
`else
        chk("t6_result_held", result_s0 ^ result_s1, R2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sbox_layer_scheduler.md
SBOX_LAYER_SCHEDULER -- requirements
Module: sbox_layer_scheduler

Interface
REQ-001 SHALL have parameter LATENCY, default 9, meaning the register-stage count of the attached masked S-box pipeline.
REQ-002 SHALL have parameter NIBBLES, default 16, meaning the number of 4-bit S-box lookups per layer.
REQ-003 SHALL have parameter FRESH_W, default 17, meaning the fresh-randomness width consumed per cycle by the S-box.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  request to process one layer; accepted only when ready=1.
REQ-007 ready  out  1  high in IDLE only.
REQ-008 state_s0 / state_s1  in  4*NIBBLES each  input state, shares 0 and 1; sampled on acceptance.
REQ-009 rnd_in  in  FRESH_W  fresh randomness from the PRNG.
REQ-010 rnd_valid  in  1  rnd_in is fresh this cycle.
REQ-011 SI_s0 / SI_s1  out  4 each  nibble shares driven to the S-box.
REQ-012 Fresh  out  FRESH_W  randomness driven to the S-box.
REQ-013 SO_s0 / SO_s1  in  4 each  S-box output shares.
REQ-014 result_s0 / result_s1  out  4*NIBBLES each  substituted state shares.
REQ-015 done  out  1  single-cycle pulse; the result is valid.
REQ-016 rnd_starve  out  1  sticky flag: randomness was missing while a token was in flight.

Function
REQ-017 FSM states are IDLE, ISSUE, DRAIN and DONE.
  - IDLE->ISSUE when start=1 at edge T; the input state is latched and the issue index is cleared.
  - ISSUE->DRAIN after nibble NIBBLES-1 is issued.
  - DRAIN->DONE when the last tag leaves the pipeline.
  - DONE->IDLE unconditionally after one cycle.
REQ-018 Nibble i SHALL be bits [4i+3:4i]; nibbles are issued in ascending order, at most one per cycle.
REQ-019 In ISSUE, a nibble SHALL be issued only in cycles with rnd_valid=1; otherwise a bubble is inserted and the index holds.
REQ-020 SI_s0/SI_s1 SHALL be 0 on bubbles and in IDLE/DONE.
REQ-021 Valid/tag tracking:
  - An internal LATENCY-deep shift register carries {valid, 4-bit index} per issue cycle.
  - When valid exits, SO_s0/SO_s1 are written into result nibble index.
REQ-022 Fresh SHALL equal rnd_in in ISSUE and DRAIN, and 0 otherwise.
REQ-023 rnd_starve SHALL set when rnd_valid=0 while any tracked valid bit is set or in ISSUE.
  - It is cleared only on the next accepted start or on reset.
REQ-024 Latency with rnd_valid held high:
  - start accepted at edge T.
  - Nibble i issued in cycle T+1+i.
  - done=1 in cycle T+1+NIBBLES+LATENCY.
REQ-025 start in any state other than IDLE SHALL be ignored, with no effect on state or data.
REQ-026 result_s0/result_s1 SHALL hold stable from done until the next accepted start.

Reset
REQ-027 Reset SHALL return to IDLE and clear all outputs, latched state, index, tag pipeline and rnd_starve to 0; ready=1 after reset.
REQ-028 Reset mid-layer SHALL abort without a done pulse; tags still in flight are discarded.

Configuration
REQ-029 With SBOX_SCHED_ZEROIZE_EN defined:
  - result_s0/result_s1 and the latched input state are cleared to 0 in the DONE->IDLE transition cycle + 1 (result visible for the done cycle only).
  - Without it, they hold until the next start.

Structure
REQ-030 Shared package sbox_sched_pkg SHALL hold the state enum, NIBBLE_W=4, and the tag struct {valid, idx}.
REQ-031 The tag shift register SHALL be sub-module sbox_tag_pipe, parameterised by LATENCY.
REQ-032 The masked S-box SHALL be external, connected via the SI_*/SO_*/Fresh ports.

Verification
REQ-033 Bench test cases:
  - s0=0x0123456789ABCDEF^M, s1=M, M=0xA5A5A5A5A5A5A5A5, rnd_valid=1 -> result_s0^result_s1=0xC6901A2B385D4E7F, done at T+26.
  - rnd_valid low for cycles T+3..T+5 -> done at T+29, same result, rnd_starve=1.
  - start pulsed during ISSUE -> ignored, single done, result unchanged.
  - rst asserted in DRAIN -> ready=1 and outputs 0 immediately, no done.
  - Back-to-back layers (start asserted the cycle after done) -> second result correct, rnd_starve cleared.
  - SBOX_SCHED_ZEROIZE_EN defined -> result=0 two cycles after done; undefined -> held.
